mlp_layer3_neuron_engine: RTL and testbench

Sequential multiply-accumulate engine for MLP output layer 3. For each of N_OUT neurons it walks N_IN input activations against the matching weight row. It then adds the per-neuron bias fetched from the layer-3 bias register file (4-bit address, 16-bit combinational read) and emits one saturated, optionally ReLU'd Q8.8 result per neuron on a valid/ready stream. It sits directly upstream of the bias register file and drives its read address.

---
 rtl/mlp_layer3_neuron_engine.sv | 126 ++++++++++++
 tb/tb_mlp_layer3_neuron_engine.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mlp_layer3_neuron_engine.sv
// Layer-3 MLP output engine: one Q8.8 MAC per cycle over N_IN activations per neuron,
// then bias add, saturation and optional ReLU, emitted on a valid/ready stream.
`timescale 1ns/1ps
module mlp_layer3_neuron_engine #(
    parameter int N_IN  = 64,
    parameter int N_OUT = 10,
    parameter int FRAC  = 8,
    parameter int ACC_W = 40,
    parameter int RELU  = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic [7:0]  in_addr,
    input  logic [15:0] in_data,
    output logic [11:0] w_addr,
    input  logic [15:0] w_data,
    output logic [3:0]  b_addr,
    input  logic [15:0] b_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_idx,
    output logic [15:0] out_data
);

    typedef enum logic [1:0] {IDLE, MAC, BIAS, OUT} state_t;

    localparam logic [7:0] I_LAST = 8'(N_IN - 1);
    localparam logic [3:0] N_LAST = 4'(N_OUT - 1);
    localparam logic signed [ACC_W:0] SAT_MAX = 32767;
    localparam logic signed [ACC_W:0] SAT_MIN = -32768;

    state_t                  state, state_nxt;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_sh;
    logic signed [31:0]      prod;
    logic signed [ACC_W:0]   sum;
    logic                    hs;

    function automatic logic signed [15:0] sat16(input logic signed [ACC_W:0] v);
        if (v > SAT_MAX)      sat16 = 16'sh7FFF;
        else if (v < SAT_MIN) sat16 = 16'sh8000;
        else                  sat16 = v[15:0];
    endfunction

    function automatic logic signed [15:0] relu_fn(input logic signed [15:0] v);
        if (RELU != 0 && v < 0) relu_fn = '0;
        else                    relu_fn = v;
    endfunction

    // Q8.8 x Q8.8 gives Q16.16; the extra sum bit keeps the bias add from wrapping before saturation
    assign prod   = $signed(in_data) * $signed(w_data);
    assign acc_sh = acc >>> FRAC;
    assign sum    = {acc_sh[ACC_W-1], acc_sh} + {{(ACC_W-15){b_data[15]}}, b_data};
    assign hs     = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start)              state_nxt = MAC;
            MAC:  if (in_addr == I_LAST)  state_nxt = BIAS;
            BIAS:                         state_nxt = OUT;
            OUT:  if (hs)                 state_nxt = (b_addr == N_LAST) ? IDLE : MAC;
            default:                      state_nxt = IDLE;
        endcase
    end

    // in_addr doubles as the activation counter and b_addr as the neuron counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy      <= 1'b0;
            in_addr   <= '0;
            w_addr    <= '0;
            b_addr    <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        busy    <= 1'b1;
                        in_addr <= '0;
                        w_addr  <= '0;
                        b_addr  <= '0;
                        acc     <= '0;
                    end
                end
                MAC: begin
                    acc <= acc + {{(ACC_W-32){prod[31]}}, prod};
                    if (in_addr != I_LAST) begin
                        in_addr <= in_addr + 8'd1;
                        w_addr  <= w_addr + 12'd1;
                    end
                end
                BIAS: begin
                    out_data  <= relu_fn(sat16(sum));
                    out_idx   <= b_addr;
                    out_valid <= 1'b1;
                end
                OUT: begin
                    if (hs) begin
                        out_valid <= 1'b0;
                        if (b_addr == N_LAST) begin
                            busy <= 1'b0;
                        end else begin
                            b_addr  <= b_addr + 4'd1;
                            in_addr <= '0;
                            w_addr  <= w_addr + 12'd1;
                            acc     <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mlp_layer3_neuron_engine.sv
// Directed bench for mlp_layer3_neuron_engine: small 4x2 engines (ReLU off/on) and a 64x10 sweep,
// with a reference model feeding scoreboard queues.
`timescale 1ns/1ps
module tb_mlp_layer3_neuron_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start, out_ready, start_b, ready_b;

    logic        busy_a, busy_r, busy_b;
    logic [7:0]  in_addr_a, in_addr_r, in_addr_b;
    logic [11:0] w_addr_a, w_addr_r, w_addr_b;
    logic [3:0]  b_addr_a, b_addr_r, b_addr_b;
    logic [15:0] in_data_a, in_data_r, in_data_b;
    logic [15:0] w_data_a, w_data_r, w_data_b;
    logic [15:0] b_data_a, b_data_r, b_data_b;
    logic        out_valid_a, out_valid_r, out_valid_b;
    logic [3:0]  out_idx_a, out_idx_r, out_idx_b;
    logic [15:0] out_data_a, out_data_r, out_data_b;

    logic [15:0] act_s [256];
    logic [15:0] wt_s  [4096];
    logic [15:0] bias_s[16];
    logic [15:0] act_b [256];
    logic [15:0] wt_b  [4096];
    logic [15:0] bias_b[16];

    assign in_data_a = act_s[in_addr_a];
    assign w_data_a  = wt_s[w_addr_a];
    assign b_data_a  = bias_s[b_addr_a];
    assign in_data_r = act_s[in_addr_r];
    assign w_data_r  = wt_s[w_addr_r];
    assign b_data_r  = bias_s[b_addr_r];
    assign in_data_b = act_b[in_addr_b];
    assign w_data_b  = wt_b[w_addr_b];
    assign b_data_b  = bias_b[b_addr_b];

    mlp_layer3_neuron_engine #(.N_IN(4), .N_OUT(2), .FRAC(8), .ACC_W(40), .RELU(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy_a),
        .in_addr(in_addr_a), .in_data(in_data_a), .w_addr(w_addr_a), .w_data(w_data_a),
        .b_addr(b_addr_a), .b_data(b_data_a), .out_valid(out_valid_a), .out_ready(out_ready),
        .out_idx(out_idx_a), .out_data(out_data_a));

    mlp_layer3_neuron_engine #(.N_IN(4), .N_OUT(2), .FRAC(8), .ACC_W(40), .RELU(1)) dut_r (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy_r),
        .in_addr(in_addr_r), .in_data(in_data_r), .w_addr(w_addr_r), .w_data(w_data_r),
        .b_addr(b_addr_r), .b_data(b_data_r), .out_valid(out_valid_r), .out_ready(out_ready),
        .out_idx(out_idx_r), .out_data(out_data_r));

    mlp_layer3_neuron_engine #(.N_IN(64), .N_OUT(10), .FRAC(8), .ACC_W(40), .RELU(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b),
        .in_addr(in_addr_b), .in_data(in_data_b), .w_addr(w_addr_b), .w_data(w_data_b),
        .b_addr(b_addr_b), .b_data(b_data_b), .out_valid(out_valid_b), .out_ready(ready_b),
        .out_idx(out_idx_b), .out_data(out_data_b));

    int checks = 0;
    int errors = 0;
    logic [35:0] sb_q[$];
    logic [19:0] sb_b[$];
    int last_w = 0;
    int step_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Independent model: 64-bit accumulate, 40-bit wrap, arithmetic shift, bias, clamp, optional ReLU
    function automatic logic [15:0] ref_out(input bit big, input int n, input bit relu);
        longint acc = 0;
        longint s;
        int nin = big ? 64 : 4;
        logic [15:0] a, w, b;
        for (int k = 0; k < nin; k++) begin
            a = big ? act_b[k] : act_s[k];
            w = big ? wt_b[n*nin+k] : wt_s[n*nin+k];
            acc += longint'($signed(a)) * longint'($signed(w));
        end
        acc = (acc <<< 24) >>> 24;
        b = big ? bias_b[n] : bias_s[n];
        s = (acc >>> 8) + longint'($signed(b));
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        if (relu && s < 0) s = 0;
        return s[15:0];
    endfunction

    task automatic push_small();
        for (int n = 0; n < 2; n++)
            sb_q.push_back({4'(n), ref_out(1'b0, n, 1'b0), ref_out(1'b0, n, 1'b1)});
    endtask

    task automatic wait_valid_s(input string tag, output int k);
        k = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            k++;
        end while (!out_valid_a && k < 400);
        if (!out_valid_a) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic pop_check_s(input string tag);
        logic [35:0] e;
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb_q.pop_front();
        chk({tag, "_idx"},    32'(out_idx_a),   32'(e[35:32]));
        chk({tag, "_data"},   32'(out_data_a),  32'(e[31:16]));
        chk({tag, "_relu"},   32'(out_data_r),  32'(e[15:0]));
        chk({tag, "_vld_r"},  32'(out_valid_r), 32'd1);
        chk({tag, "_b_addr"}, 32'(b_addr_a),    32'(e[35:32]));
    endtask

    task automatic run_small(input string tag);
        int k;
        push_small();
        start = 1'b1;
        wait_valid_s(tag, k);
        pop_check_s({tag, "_n0"});
        wait_valid_s(tag, k);
        pop_check_s({tag, "_n1"});
        @(negedge clk);
    endtask

    task automatic wait_valid_b(output int k);
        k = 0;
        do begin
            @(negedge clk);
            start_b = 1'b0;
            k++;
            if (int'(w_addr_b) != last_w) begin
                if (int'(w_addr_b) != last_w + 1) step_err++;
                last_w = int'(w_addr_b);
            end
        end while (!out_valid_b && k < 200);
        if (!out_valid_b) chk("sweep_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int k;
        logic [15:0] hold_d;
        logic [3:0]  hold_i;
        logic [11:0] hold_w;
        logic [19:0] eb;
        rst_n = 1'b0; start = 1'b0; out_ready = 1'b1; start_b = 1'b0; ready_b = 1'b1;
        for (int j = 0; j < 256; j++) begin act_s[j] = '0; act_b[j] = '0; end
        for (int j = 0; j < 4096; j++) begin wt_s[j] = '0; wt_b[j] = '0; end
        for (int j = 0; j < 16; j++) begin bias_s[j] = '0; bias_b[j] = '0; end

        // reset / idle: start pulsed while reset is held
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("rst_busy",      32'(busy_a),      32'd0);
        chk("rst_valid",     32'(out_valid_a), 32'd0);
        chk("rst_in_addr",   32'(in_addr_a),   32'd0);
        chk("rst_w_addr",    32'(w_addr_a),    32'd0);
        chk("rst_b_addr",    32'(b_addr_a),    32'd0);
        chk("rst_out_data",  32'(out_data_a),  32'd0);
        chk("rst_out_idx",   32'(out_idx_a),   32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // basic pass: 4 x (1.0 * 0.5) = 2.0, biases +1.0 / -1.0
        for (int j = 0; j < 8; j++) wt_s[j] = 16'h0080;
        for (int j = 0; j < 4; j++) act_s[j] = 16'h0100;
        bias_s[0] = 16'h0100; bias_s[1] = 16'hFF00;
        push_small();
        start = 1'b1;
        wait_valid_s("basic", k);
        chk("basic_latency", 32'(k), 32'd6);
        chk("basic_n0_const", 32'(out_data_a), 32'h0300);
        chk("basic_busy", 32'(busy_a), 32'd1);
        pop_check_s("basic_n0");
        wait_valid_s("basic", k);
        chk("basic_n1_const", 32'(out_data_a), 32'h0100);
        pop_check_s("basic_n1");
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("basic_busy_fall",  32'(busy_a),      32'd0);
        chk("basic_valid_fall", 32'(out_valid_a), 32'd0);
        @(negedge clk);
        chk("start_at_final_hs_ignored", 32'(busy_a), 32'd0);

        // saturation high, then negated weights
        for (int j = 0; j < 4; j++) act_s[j] = 16'h7FFF;
        for (int j = 0; j < 8; j++) wt_s[j] = 16'h7FFF;
        bias_s[0] = 16'h7FFF; bias_s[1] = 16'h7FFF;
        push_small();
        start = 1'b1;
        wait_valid_s("sat_hi", k);
        chk("sat_hi_const", 32'(out_data_a), 32'h7FFF);
        pop_check_s("sat_hi_n0");
        wait_valid_s("sat_hi", k);
        pop_check_s("sat_hi_n1");
        @(negedge clk);
        for (int j = 0; j < 8; j++) wt_s[j] = 16'h8001;
        push_small();
        start = 1'b1;
        wait_valid_s("sat_lo", k);
        chk("sat_lo_const",  32'(out_data_a), 32'h8000);
        chk("sat_lo_relu0",  32'(out_data_r), 32'h0000);
        pop_check_s("sat_lo_n0");
        wait_valid_s("sat_lo", k);
        pop_check_s("sat_lo_n1");
        @(negedge clk);

        // back-pressure with random small operands
        for (int j = 0; j < 4; j++) act_s[j] = 16'($urandom_range(0, 2047)) - 16'd1024;
        for (int j = 0; j < 8; j++) wt_s[j] = 16'($urandom_range(0, 2047)) - 16'd1024;
        bias_s[0] = 16'($urandom_range(0, 4095)) - 16'd2048;
        bias_s[1] = 16'($urandom_range(0, 4095)) - 16'd2048;
        out_ready = 1'b0;
        push_small();
        start = 1'b1;
        wait_valid_s("bp", k);
        hold_d = out_data_a; hold_i = out_idx_a; hold_w = w_addr_a;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            chk("bp_valid_held", 32'(out_valid_a), 32'd1);
            chk("bp_data_held",  32'(out_data_a),  32'(hold_d));
            chk("bp_idx_held",   32'(out_idx_a),   32'(hold_i));
            chk("bp_w_addr_held", 32'(w_addr_a),   32'(hold_w));
            chk("bp_b_addr_held", 32'(b_addr_a),   32'd0);
        end
        pop_check_s("bp_n0");
        out_ready = 1'b1;
        wait_valid_s("bp", k);
        pop_check_s("bp_n1");
        @(negedge clk);

        // reset in the second MAC cycle of neuron 1, then a clean rerun
        push_small();
        start = 1'b1;
        wait_valid_s("mrst", k);
        pop_check_s("mrst_n0");
        @(negedge clk);
        @(negedge clk);
        chk("mrst_in_addr_mac2", 32'(in_addr_a), 32'd1);
        chk("mrst_w_addr_mac2",  32'(w_addr_a),  32'd5);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mrst_busy",    32'(busy_a),      32'd0);
        chk("mrst_valid",   32'(out_valid_a), 32'd0);
        chk("mrst_w_addr",  32'(w_addr_a),    32'd0);
        chk("mrst_b_addr",  32'(b_addr_a),    32'd0);
        sb_q.delete();
        rst_n = 1'b1;
        @(negedge clk);
        run_small("rerun");

        // 64 x 10 sweep with random operands
        for (int j = 0; j < 64; j++) act_b[j] = 16'($urandom_range(0, 1023)) - 16'd512;
        for (int j = 0; j < 640; j++) wt_b[j] = 16'($urandom_range(0, 1023)) - 16'd512;
        for (int j = 0; j < 10; j++) bias_b[j] = 16'($urandom_range(0, 4095)) - 16'd2048;
        for (int n = 0; n < 10; n++) sb_b.push_back({4'(n), ref_out(1'b1, n, 1'b0)});
        last_w = 0; step_err = 0;
        start_b = 1'b1;
        for (int n = 0; n < 10; n++) begin
            wait_valid_b(k);
            if (sb_b.size() == 0) chk("sweep_sb_empty", 32'd0, 32'd1);
            else begin
                eb = sb_b.pop_front();
                chk("sweep_idx",    32'(out_idx_b),  32'(eb[19:16]));
                chk("sweep_b_addr", 32'(b_addr_b),   32'(eb[19:16]));
                chk("sweep_data",   32'(out_data_b), 32'(eb[15:0]));
            end
        end
        @(negedge clk);
        chk("sweep_w_last",   32'(last_w),   32'd639);
        chk("sweep_w_steps",  32'(step_err), 32'd0);
        chk("sweep_busy_end", 32'(busy_b),   32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
